// File: rtl/fifo_stream_reader_if.sv
// FIFO-read and output-stream signals of fifo_stream_reader; master is the reader side.
// The slave modport is the FIFO read port plus the downstream consumer.
interface fifo_stream_reader_if #(
  parameter int data_width = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [data_width-1:0] fifo_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [data_width-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream via a 2-entry buffer.
// Latency: read in cycle N -> m_valid in N+2; reads stop once buffer plus in-flight reach 2.
module fifo_stream_reader #(
  parameter int data_width = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  fifo_stream_reader_if.master  bus,
  output logic [CNT_W-1:0]      rd_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                  occ;
  logic [1:0]            occ_n;
  logic                  inflight;
  logic                  discard;
  logic [data_width-1:0] head;
  logic [data_width-1:0] tail;
  logic                  m_valid_q;
  logic                  pop;
  logic                  capture;
  logic [2:0]            demand;
  logic                  rd_en;

  assign occ_n   = occ;
  assign pop     = m_valid_q && bus.m_ready;
  assign capture = inflight && !discard;

  // Words already held plus the one on its way, less the one leaving this cycle.
  assign demand = {1'b0, occ_n} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en  = rst && enable && !flush && !bus.fifo_empty && (demand < 3'd2);

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ       <= EMPTY;
      inflight  <= 1'b0;
      discard   <= 1'b0;
      head      <= '0;
      tail      <= '0;
      m_valid_q <= 1'b0;
      rd_count  <= '0;
    end else begin
      inflight <= rd_en;
      discard  <= flush && inflight;
      if (pop) begin
        rd_count <= rd_count + 1'b1;
      end
      // Flush also drops a word landing on fifo_data this very cycle.
      if (flush) begin
        occ       <= EMPTY;
        m_valid_q <= 1'b0;
      end else begin
        case ({pop, capture})
          2'b10: begin
            head      <= tail;
            occ       <= (occ == TWO) ? ONE : EMPTY;
            m_valid_q <= (occ == TWO);
          end
          2'b01: begin
            if (occ == EMPTY) begin
              head <= bus.fifo_data;
              occ  <= ONE;
            end else begin
              tail <= bus.fifo_data;
              occ  <= TWO;
            end
            m_valid_q <= 1'b1;
          end
          2'b11: begin
            if (occ == ONE) begin
              head <= bus.fifo_data;
            end else begin
              head <= tail;
              tail <= bus.fifo_data;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // The issue rule must keep the two-entry buffer from ever overflowing.
  a_occ_legal: assert property (@(posedge clk) disable iff (!rst) occ_n != 2'd3);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(capture && !pop && !flush && occ == TWO));

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Downstream stage for synchronous_fifo: drains the FIFO read port and presents the words as a valid/ready stream to the consumer logic.
- Hides the FIFO's 1-cycle read latency with a 2-entry registered output buffer.
- Sustains 1 word/cycle when the FIFO is non-empty and the consumer is ready.
- Counts completed output handshakes.

Parameters:
- data_width, 8, word width; must match the FIFO's data_width.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read strobe; connects to FIFO rd_en.
- fifo_data  input  data_width  FIFO data_out; valid the cycle after fifo_rd_en is sampled high.
- enable  input  1  when low, no new FIFO reads are issued.
- flush  input  1  synchronous; discards buffered and in-flight data.
- m_valid  output  1  output word valid.
- m_ready  input  1  consumer accepts the word.
- m_data  output  data_width  output word (buffer head).
- rd_count  output  CNT_W  number of m_valid&&m_ready handshakes, modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - occ=0, inflight=0, discard=0.
  - m_valid=0, m_data=0, rd_count=0.
  - fifo_rd_en forced 0 while rst=0.
  - Data in flight at reset is lost; the FIFO shares the same reset.
- State:
  - occ ∈ {EMPTY(0), ONE(1), TWO(2)}.
  - inflight: 1-bit register = fifo_rd_en of the previous cycle.
  - Buffer: 2 registers (head, tail).
- Combinational terms:
  - pop = m_valid && m_ready.
  - fifo_rd_en = rst && enable && !flush && !fifo_empty && (occ + inflight - pop < 2).
- Capture: when inflight=1 and discard=0, fifo_data is written at the edge.
  - If occ after pop is 0, it goes to head; if 1, it goes to tail.
  - Overflow is impossible by the issue rule. Verification asserts occ never exceeds 2.
- Pop: head <= tail, occ decrements. Pop and capture in the same cycle leave occ unchanged and preserve order.
- Outputs:
  - m_valid = (occ != 0).
  - m_data = head, registered, no combinational path from fifo_data.
  - While m_valid=1 && m_ready=0, m_data and m_valid hold stable.
- Latency: from fifo_rd_en high in cycle N, the word is on m_data with m_valid=1 in cycle N+2.
- Throughput: with fifo_empty=0 and m_ready=1 continuously, fifo_rd_en stays high every cycle and m_valid stays high every cycle after fill.
- Backpressure: with m_ready=0, at most 2 reads are issued after occ=0; then fifo_rd_en=0 until a pop.
- enable=0: no new reads. In-flight data is still captured and buffered words still drain.
- flush=1 at an edge:
  - occ <= 0, m_valid drops the next cycle.
  - If inflight=1, discard <= 1 and the word arriving next cycle is dropped; discard clears after 1 cycle.
  - A pop coincident with flush still counts in rd_count.
  - rd_count itself is not cleared.
- rd_count increments on each pop and wraps from 2^CNT_W-1 to 0.
- fifo_empty=1: no read is issued that cycle; the block never reads an empty FIFO.

Test Plan:
- Reset/idle: rst=0 for 10 cycles, then release with fifo_empty=1 -> m_valid=0, fifo_rd_en=0, rd_count=0 throughout.
- Streaming: FIFO preloaded with 0x11,0x22,0x33,0x44,0x55; enable=1, m_ready=1 -> fifo_rd_en high 5 consecutive cycles. m_data shows 0x11..0x55 on consecutive cycles starting 2 cycles after the first read. rd_count=5.
- Backpressure: same 5 words, m_ready=0 -> exactly 2 reads issued, m_data holds 0x11 stable. Then toggle m_ready 1,0,1,0 (like the FIFO bench's alternating strobes) -> words arrive in order, none lost or duplicated.
- Interaction with the FIFO's alternating writes: the writer pulses wr_en every other cycle for 30 cycles with random data -> a scoreboard queue matches every m_data in order, and fifo_rd_en never asserts while fifo_empty=1.
- Flush: occ=2 (0xA1,0xA2) with a read in flight (0xA3), pulse flush for 1 cycle -> m_valid=0 next cycle and 0xA3 is never output. The next FIFO word 0xA4 is the first word output afterwards.
- Counter wrap / async reset: with CNT_W=4, perform 17 handshakes -> rd_count=1. Assert rst low mid-stream between clock edges -> m_valid and rd_count go to 0 immediately, without waiting for a clock edge.
